// File: rtl/regfile_store.sv
// Architectural register file write side: write-back commit, pending-write
// scoreboard, and a valid/ready register dump stream for debug/trace.
module regfile_store #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              update_register_id,
  input  logic [XLEN-1:0]            update_register_val,
  output logic [NREG-1:0][XLEN-1:0]  registers,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  output logic [NREG-1:0]            busy,
  input  logic                       dump_start,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [AW-1:0]              dump_idx,
  output logic [XLEN-1:0]            dump_data,
  output logic                       dump_active,
  output logic                       dump_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t            state, state_n;
  logic [NREG-1:0]   busy_n;
  logic              load;
  logic [AW-1:0]     load_idx;
  logic [XLEN-1:0]   load_val;
  logic              upd_en;

  assign upd_en = (update_register_id != '0);

  always_ff @(posedge clk) begin
    if (rst)
      registers <= '0;
    else if (upd_en)
      registers[update_register_id] <= update_register_val;
  end

  // A same-cycle issue to the retiring index is a newer producer, so set wins.
  always_comb begin
    busy_n = busy;
    if (upd_en) busy_n[update_register_id] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_n[issue_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_idx = dump_idx;
    case (state)
      IDLE: if (dump_start) begin
        state_n  = SEND;
        load     = 1'b1;
        load_idx = '0;
      end
      SEND: if (dump_ready) begin
        if (dump_idx == LAST) begin
          state_n = DONE;
        end else begin
          load     = 1'b1;
          load_idx = dump_idx + AW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write-first: a write landing on the index being loaded is forwarded.
  assign load_val = (upd_en && update_register_id == load_idx) ? update_register_val
                                                               : registers[load_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if (load) begin
      dump_idx  <= load_idx;
      dump_data <= load_val;
    end
  end

  assign dump_valid  = (state == SEND);
  assign dump_done   = (state == DONE);
  assign dump_active = (state != IDLE);

endmodule

// File: tb/tb_regfile_store.sv
// Directed bench for regfile_store: writes, scoreboard, dump streaming,
// backpressure, write-first beat load and reset abort.
module tb_regfile_store;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [AW-1:0]             update_register_id;
  logic [XLEN-1:0]           update_register_val;
  logic [NREG-1:0][XLEN-1:0] registers;
  logic                      issue_valid;
  logic [AW-1:0]             issue_rd;
  logic [NREG-1:0]           busy;
  logic                      dump_start;
  logic                      dump_valid;
  logic                      dump_ready;
  logic [AW-1:0]             dump_idx;
  logic [XLEN-1:0]           dump_data;
  logic                      dump_active;
  logic                      dump_done;

  regfile_store #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .update_register_id(update_register_id), .update_register_val(update_register_val),
    .registers(registers),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_active(dump_active), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [XLEN-1:0] exp_regs [NREG];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("%s r%0d", tag, i), registers[i], exp_regs[i]);
  endtask

  initial begin
    int ei, st3, wid, done_seen;
    logic [XLEN-1:0] ed, wval;
    logic r;

    rst = 1'b1; update_register_id = '0; update_register_val = '0;
    issue_valid = 1'b0; issue_rd = '0; dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    step();
    rst = 1'b0;
    chk_regs("reset");
    chk("reset busy", busy, 32'h0);
    chk("reset valid", {31'b0, dump_valid}, 32'h0);
    chk("reset done", {31'b0, dump_done}, 32'h0);
    chk("reset active", {31'b0, dump_active}, 32'h0);
    chk("reset idx", {27'b0, dump_idx}, 32'h0);
    chk("reset data", dump_data, 32'h0);

    // single write
    update_register_id = 5'd5; update_register_val = 32'hDEADBEEF;
    step();
    update_register_id = '0;
    exp_regs[5] = 32'hDEADBEEF;
    chk_regs("write5");

    // r0 is never written; issue to r0 never marks busy
    update_register_id = 5'd0; update_register_val = 32'hFFFFFFFF;
    step();
    chk("r0 stays 0", registers[0], 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    chk("issue r0 busy", busy, 32'h0);

    // scoreboard set, clear, set-wins
    issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("busy set 7", busy, 32'h0000_0080);
    update_register_id = 5'd7; update_register_val = 32'h77;
    step();
    chk("busy clr 7", busy, 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd7; update_register_val = 32'h70;
    step();
    issue_valid = 1'b0; update_register_id = '0;
    chk("busy set wins", busy, 32'h0000_0080);
    chk("r7 written", registers[7], 32'h70);
    update_register_id = 5'd7;
    step();
    update_register_id = '0;
    chk("busy clr again", busy, 32'h0);

    // fill every register with a distinct pattern
    for (int i = 1; i < NREG; i++) begin
      update_register_id = AW'(i); update_register_val = 32'h1000_0000 + 32'(i) * 32'h11;
      exp_regs[i] = 32'h1000_0000 + 32'(i) * 32'h11;
      step();
    end
    update_register_id = '0;
    chk_regs("fill");

    // full dump, ready tied high; extra dump_start mid-dump must be ignored
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int b = 0; b < NREG; b++) begin
      chk($sformatf("d4 valid b%0d", b), {31'b0, dump_valid}, 32'h1);
      chk($sformatf("d4 idx b%0d", b), {27'b0, dump_idx}, 32'(b));
      chk($sformatf("d4 data b%0d", b), dump_data, exp_regs[b]);
      chk($sformatf("d4 nodone b%0d", b), {31'b0, dump_done}, 32'h0);
      dump_start = (b == 5);
      step();
    end
    dump_start = 1'b0;
    chk("d4 done pulse", {31'b0, dump_done}, 32'h1);
    chk("d4 valid low", {31'b0, dump_valid}, 32'h0);
    step();
    chk("d4 done once", {31'b0, dump_done}, 32'h0);
    chk("d4 idle", {31'b0, dump_active}, 32'h0);

    // backpressure with stall on beat 3 and write-first on beat 4 load
    dump_ready = 1'b0; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    ei = 0; ed = exp_regs[0]; st3 = 0; done_seen = 0;
    for (int c = 0; c < 400 && done_seen == 0; c++) begin
      chk("d5 valid", {31'b0, dump_valid}, 32'h1);
      chk("d5 idx", {27'b0, dump_idx}, 32'(ei));
      chk("d5 data", dump_data, ed);
      r = 1'($urandom_range(0, 1)); wid = 0; wval = '0;
      if (ei == 3 && st3 < 2) begin
        r = 1'b0;
        if (st3 == 0) begin wid = 3; wval = 32'hCAFE0003; end
        st3++;
      end else if (ei == 3) begin
        r = 1'b1; wid = 4; wval = 32'hBEEF0004;
      end
      dump_ready = r; update_register_id = AW'(wid); update_register_val = wval;
      if (r) begin
        if (ei == NREG - 1) done_seen = 1;
        else begin
          ed = (wid == ei + 1) ? wval : exp_regs[ei + 1];
          ei++;
        end
      end
      if (wid != 0) exp_regs[wid] = wval;
      step();
    end
    update_register_id = '0; dump_ready = 1'b1;
    chk("d5 completed", 32'(done_seen), 32'h1);
    chk("d5 done pulse", {31'b0, dump_done}, 32'h1);
    chk("d5 r3", registers[3], 32'hCAFE0003);
    chk("d5 r4", registers[4], 32'hBEEF0004);
    step();

    // reset in the middle of a dump
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    chk("d6 busy9", busy, 32'h0000_0200);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int b = 0; b < 10; b++) step();
    chk("d6 at beat 10", {27'b0, dump_idx}, 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("d6 valid", {31'b0, dump_valid}, 32'h0);
    chk("d6 active", {31'b0, dump_active}, 32'h0);
    chk("d6 done", {31'b0, dump_done}, 32'h0);
    chk("d6 busy", busy, 32'h0);
    chk("d6 idx", {27'b0, dump_idx}, 32'h0);
    chk("d6 data", dump_data, 32'h0);
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    chk_regs("d6");
    step();
    chk("d6 no late done", {31'b0, dump_done}, 32'h0);
    chk("d6 still idle", {31'b0, dump_active}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
